// File: rtl/pipelined_divider_pkg.sv
// Shared constants for the pipelined restoring divider.
//   DVD_W : dividend width (N+M)
//   Q_W   : quotient width, also the pipeline depth (M)
//   R_W   : divisor / remainder width (N)
//   Q_SAT : quotient value reported on divide-by-zero or overflow
package pipelined_divider_pkg;
  localparam int Q_W   = 7;
  localparam int R_W   = 4;
  localparam int DVD_W = R_W + Q_W;
  localparam logic [Q_W-1:0] Q_SAT = '1;
endpackage

// File: rtl/pipelined_divider_if.sv
// Operand / result bundle of the pipelined divider.
// Handshake: en qualifies dividend/divisor on the rising clk edge; there is
// no ready, every qualified operand pair is accepted. rdy is high for exactly
// one cycle per result; quotient/remainder/div_zero/ovf hold while rdy=0.
//   master : drives en, dividend, divisor; observes results
//   slave  : the divider itself
interface pipelined_divider_if
  import pipelined_divider_pkg::*;
#(
  parameter int M = Q_W,
  parameter int N = R_W
) ();
  logic         en;
  logic [N+M-1:0] dividend;
  logic [N-1:0] divisor;
  logic [M-1:0] quotient;
  logic [N-1:0] remainder;
  logic         rdy;
  logic         div_zero;
  logic         ovf;

  modport master (
    output en, dividend, divisor,
    input  quotient, remainder, rdy, div_zero, ovf
  );

  modport slave (
    input  en, dividend, divisor,
    output quotient, remainder, rdy, div_zero, ovf
  );
endinterface

// File: rtl/pipelined_divider_div_stage.sv
// One restoring-division step plus its pipeline register.
// Ports:
//   clk, rst            : clock, async active-high reset (clears valid)
//   valid_i / valid_o   : stage occupancy
//   rem_i / rem_o       : N-bit partial remainder
//   low_i / low_o       : unconsumed dividend bits, next bit at the MSB
//   divisor_i/divisor_o : divisor travelling with the op
//   quo_i / quo_o       : quotient bits so far, newest at the LSB
//   div_zero_*, ovf_*   : flags, passed through unchanged
module div_stage
  import pipelined_divider_pkg::*;
#(
  parameter int M = Q_W,
  parameter int N = R_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [N-1:0] rem_i,
  input  logic [M-1:0] low_i,
  input  logic [N-1:0] divisor_i,
  input  logic [M-1:0] quo_i,
  input  logic         div_zero_i,
  input  logic         ovf_i,
  output logic         valid_o,
  output logic [N-1:0] rem_o,
  output logic [M-1:0] low_o,
  output logic [N-1:0] divisor_o,
  output logic [M-1:0] quo_o,
  output logic         div_zero_o,
  output logic         ovf_o
);
  logic [N:0]   trial;
  logic [N:0]   diff;
  logic         q_bit;
  logic [N-1:0] rem_d;
  logic [M-1:0] low_d;
  logic [M-1:0] quo_d;

  logic         valid_q;
  logic [N-1:0] rem_q;
  logic [M-1:0] low_q;
  logic [N-1:0] divisor_q;
  logic [M-1:0] quo_q;
  logic         div_zero_q;
  logic         ovf_q;

  always_comb begin
    trial = {rem_i, low_i[M-1]};
    diff  = trial - {1'b0, divisor_i};
    q_bit = (trial >= {1'b0, divisor_i});
    // With ovf=0 the difference always fits in N bits; with ovf=1 the
    // truncation is harmless because the result is saturated at the output.
    rem_d = q_bit ? diff[N-1:0] : trial[N-1:0];
    low_d = {low_i[M-2:0], 1'b0};
    quo_d = {quo_i[M-2:0], q_bit};
  end

  // quo_i MSB is always still zero here; diff MSB is never needed.
  logic [1:0] unused_bits;
  assign unused_bits = {quo_i[M-1], diff[N]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rem_q      <= '0;
      low_q      <= '0;
      divisor_q  <= '0;
      quo_q      <= '0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        rem_q      <= rem_d;
        low_q      <= low_d;
        divisor_q  <= divisor_i;
        quo_q      <= quo_d;
        div_zero_q <= div_zero_i;
        ovf_q      <= ovf_i;
      end
    end
  end

  assign valid_o    = valid_q;
  assign rem_o      = rem_q;
  assign low_o      = low_q;
  assign divisor_o  = divisor_q;
  assign quo_o      = quo_q;
  assign div_zero_o = div_zero_q;
  assign ovf_o      = ovf_q;
endmodule

// File: rtl/pipelined_divider.sv
// Fixed-latency, full-throughput unsigned restoring divider.
// An (N+M)-bit dividend and N-bit divisor sampled at edge e (en=1) produce
// an M-bit quotient and N-bit remainder with rdy=1 after edge e+M.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, flushes all in-flight ops
//   bus : pipelined_divider_if.slave (en, dividend, divisor in;
//         quotient, remainder, rdy, div_zero, ovf out)
module pipelined_divider
  import pipelined_divider_pkg::*;
#(
  parameter int M = Q_W,
  parameter int N = R_W
) (
  input  logic            clk,
  input  logic            rst,
  pipelined_divider_if.slave bus
);
  localparam logic [M-1:0] SAT = {M{1'b1}};

  // Index 0 is the combinational entry point; index k is stage k's register.
  logic         valid_s    [0:M];
  logic [N-1:0] rem_s      [0:M];
  logic [M-1:0] low_s      [0:M];
  logic [N-1:0] dvs_s      [0:M];
  logic [M-1:0] quo_s      [0:M];
  logic         div_zero_s [0:M];
  logic         ovf_s      [0:M];

  assign valid_s[0]    = bus.en;
  assign rem_s[0]      = bus.dividend[N+M-1:M];
  assign low_s[0]      = bus.dividend[M-1:0];
  assign dvs_s[0]      = bus.divisor;
  assign quo_s[0]      = '0;
  assign div_zero_s[0] = (bus.divisor == '0);
  // Quotient needs more than M bits exactly when the top N dividend bits
  // already reach the divisor.
  assign ovf_s[0]      = (bus.divisor != '0) && (bus.dividend[N+M-1:M] >= bus.divisor);

  for (genvar k = 0; k < M; k++) begin : g_stage
    div_stage #(.M(M), .N(N)) u_stage (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_s[k]),
      .rem_i      (rem_s[k]),
      .low_i      (low_s[k]),
      .divisor_i  (dvs_s[k]),
      .quo_i      (quo_s[k]),
      .div_zero_i (div_zero_s[k]),
      .ovf_i      (ovf_s[k]),
      .valid_o    (valid_s[k+1]),
      .rem_o      (rem_s[k+1]),
      .low_o      (low_s[k+1]),
      .divisor_o  (dvs_s[k+1]),
      .quo_o      (quo_s[k+1]),
      .div_zero_o (div_zero_s[k+1]),
      .ovf_o      (ovf_s[k+1])
    );
  end

  // The last stage has consumed every dividend bit and no longer needs the divisor.
  logic [M+N-1:0] unused_tail;
  assign unused_tail = {low_s[M], dvs_s[M]};

  logic [M-1:0] quotient_d,  quotient_q;
  logic [N-1:0] remainder_d, remainder_q;
  logic         div_zero_d,  div_zero_q;
  logic         ovf_d,       ovf_q;
  logic         rdy_q;

  always_comb begin
    quotient_d  = quo_s[M];
    remainder_d = rem_s[M];
    div_zero_d  = 1'b0;
    ovf_d       = 1'b0;
    if (div_zero_s[M]) begin
      quotient_d  = SAT;
      remainder_d = '0;
      div_zero_d  = 1'b1;
    end else if (ovf_s[M]) begin
      quotient_d  = SAT;
      remainder_d = '0;
      ovf_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      rdy_q <= valid_s[M];
      // Results only change on a valid op; bubbles leave them holding.
      if (valid_s[M]) begin
        quotient_q  <= quotient_d;
        remainder_q <= remainder_d;
        div_zero_q  <= div_zero_d;
        ovf_q       <= ovf_d;
      end
    end
  end

  assign bus.rdy       = rdy_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.ovf       = ovf_q;
endmodule
